// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_pkg;

    // Controller states; the datapath strobes are decoded from these.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARK,
        ST_KEYUPD,
        ST_INC,
        ST_SUB,
        ST_SHIFT,
        ST_MIX,
        ST_DONE
    } ctrl_state_t;

    // key_size encodings as presented at the load interface.
    typedef enum logic [1:0] {
        KS_128  = 2'b00,
        KS_192  = 2'b01,
        KS_256  = 2'b10,
        KS_RSVD = 2'b11
    } key_size_t;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Bit positions inside the one-hot operation strobe.
    localparam int OP_ARK   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_SHIFT = 2;
    localparam int OP_MIX   = 3;

    // Number of rounds for a legal key size; the reserved code never reaches here.
    function automatic logic [3:0] nr_of(input logic [1:0] ks);
        case (ks)
            KS_192:  return NR_192;
            KS_256:  return NR_256;
            default: return NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Load/done handshake, key-schedule handshake and datapath strobes of the sequencer.
interface aes_round_ctrl_if;
    logic       start;
    logic [1:0] key_size;
    logic       decrypt;
    logic       key_ready;
    logic       ack;
    logic       busy;
    logic       done;
    logic       err;
    logic       key_req;
    logic [3:0] round;
    logic [3:0] key_round;
    logic       inverse;
    logic [3:0] operation;

    // Requester / environment side.
    modport master (
        output start, key_size, decrypt, key_ready, ack,
        input  busy, done, err, key_req, round, key_round, inverse, operation
    );

    // Sequencer side.
    modport slave (
        input  start, key_size, decrypt, key_ready, ack,
        output busy, done, err, key_req, round, key_round, inverse, operation
    );
endinterface

// File: rtl/aes_lat_counter.sv
// S-box latency wait counter: holds LAT while loaded, counts down to zero otherwise.
module aes_lat_counter #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    logic [1:0] cnt;

    // Reload outside SUB so the first SUB cycle starts from the full latency.
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 2'd0;
        end else if (load) begin
            cnt <= 2'(LAT);
        end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end
    end

    assign expired = (cnt == 2'd0);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks the round operations and key-schedule handshake.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_LAT        = 1,
    parameter bit          SUPPORT_DECRYPT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    aes_round_ctrl_if.slave  bus
);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic [3:0]  round_q;
    logic [3:0]  nr_q;
    logic        inverse_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        key_req_q;
    logic [3:0]  op_q;
    logic        dec_in;
    logic        load_ok;
    logic        last_round;
    logic        sub_done;

    assign dec_in     = SUPPORT_DECRYPT ? bus.decrypt : 1'b0;
    assign load_ok    = bus.start && (bus.key_size != KS_RSVD);
    assign last_round = (round_q == nr_q);

    aes_lat_counter #(.LAT(SBOX_LAT)) u_lat (
        .clk     (clk),
        .reset   (reset),
        .load    (state != ST_SUB),
        .expired (sub_done)
    );

    // Next-state selection; encrypt and inverse cipher share states in a different order.
    // NOTE: next_state is defaulted first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (load_ok) next_state = ST_ARK;
            ST_ARK:    next_state = ST_KEYUPD;
            ST_KEYUPD: begin
                if (bus.key_ready) begin
                    if (last_round)                          next_state = ST_DONE;
                    else if (inverse_q && round_q != 4'd0)   next_state = ST_MIX;
                    else                                     next_state = ST_INC;
                end
            end
            ST_INC:    next_state = inverse_q ? ST_SHIFT : ST_SUB;
            ST_SUB:    if (sub_done) next_state = inverse_q ? ST_ARK : ST_SHIFT;
            ST_SHIFT: begin
                if (inverse_q)       next_state = ST_SUB;
                else if (last_round) next_state = ST_ARK;
                else                 next_state = ST_MIX;
            end
            ST_MIX:    next_state = inverse_q ? ST_INC : ST_ARK;
            ST_DONE:   if (bus.ack) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // State, round bookkeeping and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            round_q   <= 4'd0;
            nr_q      <= NR_128;
            inverse_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            key_req_q <= 1'b0;
            op_q      <= 4'd0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && load_ok) begin
                nr_q      <= nr_of(bus.key_size);
                inverse_q <= dec_in;
                round_q   <= 4'd0;
            end
            if (state == ST_INC && !last_round) begin
                round_q <= round_q + 4'd1;
            end
            err_q            <= (state == ST_IDLE) && bus.start && (bus.key_size == KS_RSVD);
            busy_q           <= !(next_state inside {ST_IDLE, ST_DONE});
            done_q           <= (next_state == ST_DONE);
            key_req_q        <= (next_state == ST_KEYUPD);
            op_q[OP_ARK]     <= (next_state == ST_ARK);
            op_q[OP_SUB]     <= (next_state == ST_SUB);
            op_q[OP_SHIFT]   <= (next_state == ST_SHIFT);
            op_q[OP_MIX]     <= (next_state == ST_MIX);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.key_req   = key_req_q;
    assign bus.round     = round_q;
    assign bus.key_round = inverse_q ? (nr_q - round_q) : round_q;
    assign bus.inverse   = inverse_q;
    assign bus.operation = op_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl against an operation-stream reference model.
module tb_aes_round_ctrl;

    localparam int L = 1;

    localparam logic [3:0] O_ARK   = 4'b0001;
    localparam logic [3:0] O_SUB   = 4'b0010;
    localparam logic [3:0] O_SHIFT = 4'b0100;
    localparam logic [3:0] O_MIX   = 4'b1000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    aes_round_ctrl_if bus();

    aes_round_ctrl #(.SBOX_LAT(L), .SUPPORT_DECRYPT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One expected cycle of the block: strobes, round, key index and key_ready to drive.
    typedef struct {
        logic [3:0] op;
        logic [3:0] rnd;
        logic [3:0] kidx;
        logic       kreq;
        logic       kr;
    } step_t;

    step_t sched[$];
    int    stall_plan[15];
    int    kreq_obs[15];
    int    cmp_count = 0;
    int    err_count = 0;

    function automatic logic [16:0] obs();
        return {bus.busy, bus.done, bus.err, bus.key_req, bus.round,
                bus.key_round, bus.inverse, bus.operation};
    endfunction

    task automatic push(input logic [3:0] op, input int rnd, input int nr,
                        input bit inv, input bit kreq, input bit kr);
        step_t s;
        s.op   = op;
        s.rnd  = 4'(rnd);
        s.kidx = 4'(inv ? nr - rnd : rnd);
        s.kreq = kreq;
        s.kr   = kr;
        sched.push_back(s);
    endtask

    task automatic push_keyupd(input int r, input int nr, input bit inv);
        for (int k = 0; k < stall_plan[r]; k++) push(4'd0, r, nr, inv, 1'b1, 1'b0);
        push(4'd0, r, nr, inv, 1'b1, 1'b1);
    endtask

    // Operation stream of a full block written from the round structure of AES.
    task automatic build(input int nr, input bit inv);
        sched.delete();
        push(O_ARK, 0, nr, inv, 1'b0, 1'b1);
        push_keyupd(0, nr, inv);
        for (int r = 1; r <= nr; r++) begin
            push(4'd0, r - 1, nr, inv, 1'b0, 1'b1);
            if (!inv) begin
                for (int k = 0; k <= L; k++) push(O_SUB, r, nr, inv, 1'b0, 1'b1);
                push(O_SHIFT, r, nr, inv, 1'b0, 1'b1);
                if (r < nr) push(O_MIX, r, nr, inv, 1'b0, 1'b1);
                push(O_ARK, r, nr, inv, 1'b0, 1'b1);
                push_keyupd(r, nr, inv);
            end else begin
                push(O_SHIFT, r, nr, inv, 1'b0, 1'b1);
                for (int k = 0; k <= L; k++) push(O_SUB, r, nr, inv, 1'b0, 1'b1);
                push(O_ARK, r, nr, inv, 1'b0, 1'b1);
                push_keyupd(r, nr, inv);
                if (r < nr) push(O_MIX, r, nr, inv, 1'b0, 1'b1);
            end
        end
    endtask

    // Runs one block from IDLE through DONE (held 'hold' cycles) back to IDLE.
    task automatic run_block(input string tag, input int ks, input bit inv,
                             input int hold, output int measured);
        int          nr;
        logic [16:0] exp_v;
        logic [16:0] got;
        nr = 10 + 2 * ks;
        build(nr, inv);
        measured = -1;
        for (int i = 0; i < 15; i++) kreq_obs[i] = 0;
        bus.start     = 1'b1;
        bus.key_size  = 2'(ks);
        bus.decrypt   = inv;
        bus.ack       = 1'b0;
        bus.key_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        foreach (sched[i]) begin
            exp_v = {1'b1, 1'b0, 1'b0, sched[i].kreq, sched[i].rnd, sched[i].kidx,
                     inv, sched[i].op};
            got = obs();
            cmp_count++;
            if (got !== exp_v) begin
                err_count++;
                $display("FAIL %s cycle %0d: {busy,done,err,key_req,round,key_round,inverse,op} got %b required %b",
                         tag, i + 1, got, exp_v);
            end
            if (bus.done === 1'b1 && measured < 0) measured = i + 1;
            if (bus.key_req === 1'b1 && bus.round <= 4'd14) kreq_obs[bus.round]++;
            bus.key_ready = sched[i].kr;
            bus.start     = 1'($urandom);
            bus.key_size  = 2'($urandom);
            bus.decrypt   = 1'($urandom);
            @(posedge clk); @(negedge clk);
        end
        if (bus.done === 1'b1 && measured < 0) measured = sched.size() + 1;
        for (int h = 0; h <= hold; h++) begin
            bus.start = 1'b1;
            bus.ack   = 1'b0;
            exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 4'(nr), 4'(inv ? 0 : nr), inv, 4'd0};
            got = obs();
            cmp_count++;
            if (got !== exp_v) begin
                err_count++;
                $display("FAIL %s done hold %0d: got %b required %b", tag, h, got, exp_v);
            end
            if (h < hold) begin
                @(posedge clk); @(negedge clk);
            end
        end
        bus.ack   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 4'(nr), 4'(inv ? 0 : nr), inv, 4'd0};
            got = obs();
            cmp_count++;
            if (got !== exp_v) begin
                err_count++;
                $display("FAIL %s idle after ack %0d: got %b required %b", tag, c, got, exp_v);
            end
            @(posedge clk); @(negedge clk);
        end
        bus.key_ready = 1'b1;
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 15; i++) stall_plan[i] = 0;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        @(negedge clk);
        got = obs();
        cmp_count++;
        if (got !== 17'd0) begin
            err_count++;
            $display("FAIL reset outputs: got %b required 0", got);
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        got = obs();
        cmp_count++;
        if (got !== 17'd0) begin
            err_count++;
            $display("FAIL idle after release: got %b required 0", got);
        end
    endtask

    task automatic test_enc128();
        int m;
        clear_stalls();
        run_block("enc128", 0, 1'b0, 0, m);
        cmp_count++;
        if (m !== 72) begin
            err_count++;
            $display("FAIL enc128 latency: got %0d required 72", m);
        end
    endtask

    task automatic test_dec256();
        int m;
        clear_stalls();
        run_block("dec256", 2, 1'b1, 0, m);
        cmp_count++;
        if (m !== 100) begin
            err_count++;
            $display("FAIL dec256 latency: got %0d required 100", m);
        end
    endtask

    task automatic test_stall();
        int m;
        clear_stalls();
        stall_plan[3] = 5;
        run_block("stall", 0, 1'b0, 0, m);
        cmp_count++;
        if (m !== 77) begin
            err_count++;
            $display("FAIL stall latency: got %0d required 77", m);
        end
        cmp_count++;
        if (kreq_obs[3] !== 6) begin
            err_count++;
            $display("FAIL stall key_req cycles at round 3: got %0d required 6", kreq_obs[3]);
        end
    endtask

    task automatic test_err();
        bus.start    = 1'b1;
        bus.key_size = 2'b11;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        cmp_count++;
        if ({bus.err, bus.busy, bus.done} !== 3'b100) begin
            err_count++;
            $display("FAIL err pulse: {err,busy,done} got %b required 100", {bus.err, bus.busy, bus.done});
        end
        @(posedge clk); @(negedge clk);
        cmp_count++;
        if ({bus.err, bus.busy, bus.done, bus.operation} !== 7'd0) begin
            err_count++;
            $display("FAIL err one cycle: {err,busy,done,op} got %b required 0",
                     {bus.err, bus.busy, bus.done, bus.operation});
        end
    endtask

    task automatic test_async_reset();
        bit          found;
        int          m;
        logic [16:0] got;
        clear_stalls();
        found         = 1'b0;
        bus.start     = 1'b1;
        bus.key_size  = 2'b00;
        bus.decrypt   = 1'b0;
        bus.key_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (bus.round === 4'd6 && bus.operation === O_SUB) found = 1'b1;
            else begin
                @(posedge clk); @(negedge clk);
            end
        end
        cmp_count++;
        if (!found) begin
            err_count++;
            $display("FAIL reach round 6 SUB: got not reached required reached");
        end
        #2 reset = 1'b0;
        #1 got = obs();
        cmp_count++;
        if (got !== 17'd0) begin
            err_count++;
            $display("FAIL async reset outputs: got %b required 0", got);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        got = obs();
        cmp_count++;
        if (got !== 17'd0) begin
            err_count++;
            $display("FAIL abandoned block: got %b required 0", got);
        end
        run_block("after_reset", 0, 1'b0, 0, m);
        cmp_count++;
        if (m !== 72) begin
            err_count++;
            $display("FAIL after reset latency: got %0d required 72", m);
        end
    endtask

    task automatic test_done_hold();
        int m;
        clear_stalls();
        run_block("enc192_hold", 1, 1'b0, 4, m);
        cmp_count++;
        if (m !== 86) begin
            err_count++;
            $display("FAIL enc192 latency: got %0d required 86", m);
        end
    endtask

    task automatic test_random();
        int ks, hold, m, nr, total_stall, exp_lat;
        bit inv;
        for (int n = 0; n < 6; n++) begin
            ks   = int'($urandom_range(0, 2));
            inv  = 1'($urandom);
            hold = int'($urandom_range(0, 3));
            nr   = 10 + 2 * ks;
            total_stall = 0;
            clear_stalls();
            for (int r = 0; r <= nr; r++) begin
                if ($urandom_range(0, 3) == 0) stall_plan[r] = int'($urandom_range(1, 4));
                total_stall += stall_plan[r];
            end
            run_block("random", ks, inv, hold, m);
            exp_lat = 1 + 2 + (nr - 1) * (L + 6) + (L + 5) + total_stall;
            cmp_count++;
            if (m !== exp_lat) begin
                err_count++;
                $display("FAIL random %0d latency: got %0d required %0d", n, m, exp_lat);
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.key_size  = 2'b00;
        bus.decrypt   = 1'b0;
        bus.key_ready = 1'b1;
        bus.ack       = 1'b0;
        test_reset();
        test_enc128();
        test_dec256();
        test_stall();
        test_err();
        test_async_reset();
        test_done_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Parametrised AES round sequencer: the control FSM driving the datapath's round-operation strobes and the key-schedule handshake.
- Supports AES-128/192/256 (10/12/14 rounds), encrypt and inverse-cipher decrypt, and a configurable S-box latency.
- Sits between the top-level load/done interface and the state-array datapath plus key-expansion block.
- Owns the round counter internally, replacing an externally supplied round count.

Parameters:
SBOX_LAT, 1, extra cycles SubBytes/InvSubBytes needs after its strobe; legal range 0..3.
SUPPORT_DECRYPT, 1, 0 removes the decrypt path; decrypt input is ignored and treated as 0.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  request a new block; sampled only in IDLE
key_size  input  2  00=128, 01=192, 10=256, 11=reserved; sampled with start
decrypt  input  1  1=inverse cipher; sampled with start
key_ready  input  1  key schedule has the requested round key valid
ack  input  1  consumer has taken the result; releases DONE
busy  output  1  high in every state except IDLE and DONE
done  output  1  high while in DONE
err  output  1  one-cycle pulse when start is seen with key_size=11
key_req  output  1  high while in KEYUPD
round  output  4  current round 0..Nr
key_round  output  4  round-key index: round when encrypting, Nr-round when decrypting
inverse  output  1  latched decrypt; the datapath selects inverse operations from this
operation  output  4  one-hot: [0]=AddRoundKey, [1]=(Inv)SubBytes, [2]=(Inv)ShiftRows, [3]=(Inv)MixColumns

Behaviour:
- States: IDLE, ARK, KEYUPD, INC, SUB, SHIFT, MIX, DONE. Encode them as one enum.
- Reset (asynchronous, any time, including mid-block):
  - state=IDLE, round=0, latched Nr=10, inverse=0.
  - All outputs are 0.
  - A partially processed block is abandoned; no done is produced.
- IDLE:
  - start with key_size 00/01/10: latch Nr (10/12/14) and inverse, round<=0, go to ARK.
  - start with key_size 11: pulse err for one cycle, stay in IDLE.
- ARK: operation=0001 for one cycle, then go to KEYUPD.
- KEYUPD:
  - key_req=1; remain in KEYUPD while key_ready=0.
  - When key_ready=1, exit in that same cycle. Minimum stay is 1 cycle.
- INC: round<=round+1 at exit; one cycle.
- SUB: operation=0010 for SBOX_LAT+1 consecutive cycles, using an internal wait counter.
- SHIFT: operation=0100 for one cycle.
- MIX: operation=1000 for one cycle.
- Encrypt transitions:
  - KEYUPD exit goes to DONE if round==Nr, else to INC.
  - INC -> SUB -> SHIFT.
  - SHIFT goes to ARK if round==Nr, else to MIX; MIX -> ARK.
- Decrypt transitions:
  - KEYUPD exit goes to DONE if round==Nr, else to MIX if round!=0, else to INC.
  - MIX -> INC.
  - INC -> SHIFT -> SUB -> ARK.
- DONE:
  - done=1; hold until ack=1, then go to IDLE.
  - start is ignored in DONE, including when it coincides with ack.
- round never exceeds Nr. Compare round against the latched Nr, never against live key_size.
- key_round is combinational from round and latched Nr/inverse, so it is valid one cycle before each ARK.
- Latency with key_ready tied high, counted from the start edge:
  - Initial rounds cost ARK+KEYUPD = 2 cycles.
  - Each middle round costs SBOX_LAT+6 cycles.
  - The final round costs SBOX_LAT+5 cycles.
  - AES-128, SBOX_LAT=1: DONE is entered 72 cycles after the start edge, in both modes.
- Every KEYUPD cycle with key_ready=0 adds one cycle to the total latency.

Decomposition:
- Package aes_pkg holds:
  - ctrl state enum
  - key_size encodings
  - Nr constants NR_128=10, NR_192=12, NR_256=14
  - operation bit-index constants
  - nr_of(key_size) function
- Factor the SUB wait counter as the sub-module aes_lat_counter: load SBOX_LAT, count down, assert expired at zero.

Test Plan:
- AES-128 encrypt, SBOX_LAT=1, key_ready=1 -> operation sequence ARK,(SUB,SUB,SHIFT,MIX,ARK)x9,SUB,SUB,SHIFT,ARK; done at cycle 72; round ends at 10.
- AES-256 decrypt -> first ARK has key_round=14; operation order per round is SHIFT,SUB,ARK,MIX; the final round has no MIX; key_round ends at 0; done at cycle 100.
- key_ready held low 5 cycles at round 3 KEYUPD -> key_req high 6 cycles; round holds at 3; done 5 cycles later than baseline.
- start with key_size=11 -> err pulses for exactly 1 cycle; busy stays 0; state stays IDLE.
- reset asserted asynchronously mid-SUB at round 6 -> all outputs 0 immediately, without waiting for a clock edge; a new start after release completes normally.
- DONE held 4 cycles with ack=0 and start=1 -> done stays 1, start ignored; ack=1 -> IDLE next cycle.
